// File: rtl/seq_ctrl_pkg.sv
// Shared state encodings, default sizing and the length clamp used by the stream sequencer.
package seq_ctrl_pkg;

   localparam int TICK_DIV_DEFAULT = 50000000;
   localparam int MAX_LEN_DEFAULT  = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      WAIT   = 3'd2,
      DRIVE  = 3'd3,
      SAMPLE = 3'd4,
      DONE   = 3'd5
   } state_t;

   function automatic logic [4:0] clamp_len(input logic [4:0] len, input int unsigned max_len);
      if (32'(len) > max_len) begin
         return 5'(max_len);
      end
      return len;
   endfunction

endpackage

// File: rtl/seq_stream_controller_tick_divider.sv
// Counts TICK_DIV enabled cycles and flags the last one; clear forces the count back to zero.
module tick_divider #(
   parameter int TICK_DIV = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam int W = $clog2(TICK_DIV + 1);
   localparam logic [W-1:0] TC_VAL = W'(TICK_DIV - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign tc_o = enable_i && (count_q == TC_VAL);

   always_comb begin
      count_d = count_q;
      if (clear_i || tc_o) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seq_stream_controller.sv
// Steps the serial sequence detector through a stored pattern, one bit per divider period,
// counting the matches it reports and pulsing done at the end of a complete run.
module seq_stream_controller
   import seq_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT,
   parameter int MAX_LEN  = MAX_LEN_DEFAULT
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               load,
   input  logic [MAX_LEN-1:0] pattern_in,
   input  logic [4:0]         length_in,
   input  logic               start,
   input  logic               abort,
   input  logic               det_match,
   output logic               det_w,
   output logic               det_step,
   output logic               det_resetn,
   output logic               busy,
   output logic               done,
   output logic [4:0]         match_count,
   output logic [4:0]         bit_index
);

   localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   state_t             state_q;
   logic [MAX_LEN-1:0] pattern_q;
   logic [4:0]         length_q;
   logic [4:0]         match_count_q;
   logic [4:0]         bit_index_q;
   logic               det_w_q;
   logic               done_q;

   logic [4:0]         length_d;
   logic [4:0]         bit_index_d;
   logic               tick_tc;

   // A load in the same cycle as start must be visible to the start decision.
   always_comb begin
      length_d    = load ? clamp_len(length_in, MAX_LEN) : length_q;
      bit_index_d = bit_index_q + 5'd1;
   end

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clock    (clock),
      .resetn   (resetn),
      .clear_i  (state_q != WAIT),
      .enable_i (state_q == WAIT),
      .tc_o     (tick_tc)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q       <= IDLE;
         pattern_q     <= '0;
         length_q      <= '0;
         match_count_q <= '0;
         bit_index_q   <= '0;
         det_w_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  pattern_q <= pattern_in;
                  length_q  <= length_d;
               end
               if (start) begin
                  if (length_d != 5'd0) begin
                     state_q <= CLEAR;
                  end else begin
                     done_q        <= 1'b1;
                     match_count_q <= '0;
                  end
               end
            end
            CLEAR: begin
               match_count_q <= '0;
               bit_index_q   <= '0;
               state_q       <= WAIT;
            end
            WAIT: begin
               if (tick_tc) begin
                  det_w_q <= pattern_q[bit_index_q[IDXW-1:0]];
                  state_q <= DRIVE;
               end
            end
            DRIVE: begin
               state_q <= SAMPLE;
            end
            SAMPLE: begin
               // The bit was already stepped into the detector, so its result is kept even on abort.
               if (det_match) begin
                  match_count_q <= match_count_q + 5'd1;
               end
               bit_index_q <= bit_index_d;
               if (bit_index_d == length_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= WAIT;
               end
            end
            DONE: begin
               det_w_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         if (abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            det_w_q <= 1'b0;
         end
      end
   end

   assign det_w       = det_w_q;
   assign det_step    = (state_q == DRIVE);
   assign det_resetn  = (state_q != CLEAR);
   assign busy        = (state_q == CLEAR) || (state_q == WAIT) ||
                        (state_q == DRIVE) || (state_q == SAMPLE);
   assign done        = done_q;
   assign match_count = match_count_q;
   assign bit_index   = bit_index_q;

endmodule
